// File: rtl/f7_word_packer.sv
// f7_word_packer: packs 7-bit float codes {exp[2:0],mant[3:0]} from a
// valid/ready stream into LANES-wide output words. Lane 0 holds the oldest
// code. A word is emitted when it fills, when a code carries in_last, or
// when flush is seen with lanes held.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid & ready are both 1. The producer holds its payload stable
// while valid & ~ready. in_ready = ~out_valid | out_ready is a
// combinational path from out_ready, so a consumer taking the word frees
// the register for a new code in the same cycle.
module f7_word_packer #(
  parameter int LANES = 4,
  parameter int CNTW  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_code,
  input  logic                 in_last,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7*LANES-1:0]   out_data,
  output logic [2:0]           out_count,
  output logic                 out_last,
  output logic [CNTW-1:0]      words_sent,
  output logic [0:0]           dbg_state
);

  // FILL: accumulating, output register free or draining.
  // FULL_WAIT: output word held because the consumer is not ready.
  localparam logic [0:0] ST_FILL      = 1'b0;
  localparam logic [0:0] ST_FULL_WAIT = 1'b1;

  localparam logic [2:0] LANES_C = 3'(LANES);

  logic [7*LANES-1:0] acc;
  logic [7*LANES-1:0] acc_next;
  logic [2:0]         cnt;
  logic [2:0]         cnt_next;
  logic               flush_pend;
  logic               accept;
  logic               want_flush;
  logic               do_emit;

  assign in_ready   = ~out_valid | out_ready;
  assign accept     = in_valid & in_ready;
  assign want_flush = flush | flush_pend;

  // An emit needs the output register free; accepted codes imply that
  // already, a flush alone may have to wait (flush_pend).
  assign do_emit = in_ready &
                   ((accept & ((cnt_next == LANES_C) | in_last)) |
                    (want_flush & (cnt_next != 3'd0)));

  assign dbg_state = (out_valid & ~out_ready) ? ST_FULL_WAIT : ST_FILL;

  // Accumulator view including the code accepted this cycle.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (cnt == 3'(k)) acc_next[7*k +: 7] = in_code;
      end
      cnt_next = cnt + 3'd1;
    end
  end

  // Lane accumulator, lane count and sticky flush request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= 3'd0;
      flush_pend <= 1'b0;
    end else if (do_emit) begin
      acc        <= '0;
      cnt        <= 3'd0;
      flush_pend <= 1'b0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (flush & (cnt_next != 3'd0)) flush_pend <= 1'b1;
    end
  end

  // Output word register and its valid flag; unfilled lanes are zero
  // because the accumulator is cleared after every emit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= 3'd0;
      out_last  <= 1'b0;
    end else if (do_emit) begin
      out_valid <= 1'b1;
      out_data  <= acc_next;
      out_count <= cnt_next;
      out_last  <= accept & in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accepted-word statistics, wrapping at 2^CNTW.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_sent <= '0;
    end else if (out_valid & out_ready) begin
      words_sent <= words_sent + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_f7_word_packer.sv
// Bench for f7_word_packer: directed scenarios plus a randomized run,
// scored against a list-level model of the packing rules.
module tb_f7_word_packer;

  localparam int LANES = 4;
  localparam int CNTW  = 8;
  localparam int DW    = 7 * LANES;
  localparam int W     = DW + 4;   // {last, count[2:0], data}

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_code;
  logic            in_last;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_count;
  logic            out_last;
  logic [CNTW-1:0] words_sent;
  logic [0:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  f7_word_packer #(.LANES(LANES), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_last(in_last), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last),
    .words_sent(words_sent), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [6:0]      part_q[$];
  logic [W-1:0]    exp_q[$];
  bit              pend;
  logic [CNTW-1:0] sent_cnt;

  initial begin
    pend     = 1'b0;
    sent_cnt = '0;
  end

  // Scoreboard: sampled on the falling edge, when inputs and outputs are stable
  always @(negedge clock) begin : sb
    bit           free;
    bit           acc;
    logic [W-1:0] w;
    logic [DW-1:0] d;
    if (reset) begin
      part_q.delete();
      exp_q.delete();
      pend     = 1'b0;
      sent_cnt = '0;
    end else begin
      free = !out_valid || out_ready;
      total++;
      if (in_ready !== free) begin
        bad++;
        $display("FAIL sb_in_ready got=%b exp=%b t=%0t", in_ready, free, $time);
      end
      if (out_valid && out_ready) begin
        sent_cnt = sent_cnt + 1'b1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_word got=%h t=%0t", {out_last, out_count, out_data}, $time);
        end else begin
          w = exp_q.pop_front();
          if ({out_last, out_count, out_data} !== w) begin
            bad++;
            $display("FAIL sb_word got=%h exp=%h t=%0t", {out_last, out_count, out_data}, w, $time);
          end
        end
      end
      acc = in_valid && free;
      if (acc) part_q.push_back(in_code);
      if (free && ((acc && (part_q.size() == LANES || in_last)) ||
                   ((flush || pend) && part_q.size() > 0))) begin
        d = '0;
        for (int k = 0; k < part_q.size(); k++) d = d | (DW'(part_q[k]) << (7 * k));
        exp_q.push_back({acc && in_last, 3'(part_q.size()), d});
        part_q.delete();
        pend = 1'b0;
      end else if (flush && part_q.size() > 0) begin
        pend = 1'b1;
      end
    end
  end

  // Driver tasks
  task automatic send_code(input logic [6:0] c, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = c;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout code=%h in_ready=%b required=1", c, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    @(negedge clock);
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b required=0", exp_q.size(), out_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  // Scenarios
  task automatic test_reset;
    pulse_reset();
    total++;
    if ({out_valid, out_data, out_count, out_last, words_sent, dbg_state, in_ready} !==
        {1'b0, {DW{1'b0}}, 3'd0, 1'b0, {CNTW{1'b0}}, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d l=%b ws=%0d st=%b rdy=%b required all 0, rdy=1",
               out_valid, out_data, out_count, out_last, words_sent, dbg_state, in_ready);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_full_word;
    logic [DW-1:0] exp_d;
    exp_d = {7'h44, 7'h33, 7'h22, 7'h11};
    out_ready = 1'b1;
    send_code(7'h11, 1'b0);
    send_code(7'h22, 1'b0);
    send_code(7'h33, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_early_valid got=%b required=0", out_valid);
    end
    send_code(7'h44, 1'b0);
    total++;
    if ({out_valid, out_data, out_count, out_last} !== {1'b1, exp_d, 3'd4, 1'b0}) begin
      bad++;
      $display("FAIL full_word got v=%b d=%h c=%0d l=%b required v=1 d=%h c=4 l=0",
               out_valid, out_data, out_count, out_last, exp_d);
    end
    drain();
  endtask

  task automatic test_last;
    out_ready = 1'b1;
    send_code(7'h05, 1'b0);
    send_code(7'h7F, 1'b1);
    total++;
    if ({out_valid, out_data, out_count, out_last} !== {1'b1, 28'h0003F85, 3'd2, 1'b1}) begin
      bad++;
      $display("FAIL last_word got v=%b d=%h c=%0d l=%b required v=1 d=0003f85 c=2 l=1",
               out_valid, out_data, out_count, out_last);
    end
    send_code(7'h01, 1'b0);
    send_code(7'h02, 1'b0);
    send_code(7'h03, 1'b0);
    send_code(7'h04, 1'b1);
    total++;
    if ({out_data, out_count, out_last} !== {7'h04, 7'h03, 7'h02, 7'h01, 3'd4, 1'b1}) begin
      bad++;
      $display("FAIL last_fill_word got d=%h c=%0d l=%b required d=%h c=4 l=1",
               out_data, out_count, out_last, {7'h04, 7'h03, 7'h02, 7'h01});
    end
    drain();
  endtask

  task automatic test_stall;
    logic [DW-1:0]   held;
    logic [CNTW-1:0] ws0;
    held = {7'h0D, 7'h0C, 7'h0B, 7'h0A};
    out_ready = 1'b0;
    send_code(7'h0A, 1'b0);
    send_code(7'h0B, 1'b0);
    send_code(7'h0C, 1'b0);
    send_code(7'h0D, 1'b0);
    in_valid = 1'b1;
    in_code  = 7'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if ({in_ready, out_valid, out_data, dbg_state} !== {1'b0, 1'b1, held, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b d=%h st=%b required rdy=0 v=1 d=%h st=1",
                 i, in_ready, out_valid, out_data, dbg_state, held);
      end
    end
    ws0 = sent_cnt;
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_ready got=%b required=1", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if ({out_valid, out_data, out_count, out_last} !== {1'b1, 28'h0000055, 3'd1, 1'b1}) begin
      bad++;
      $display("FAIL stall_no_bubble got v=%b d=%h c=%0d l=%b required v=1 d=0000055 c=1 l=1",
               out_valid, out_data, out_count, out_last);
    end
    total++;
    if (words_sent !== ws0 + 1'b1) begin
      bad++;
      $display("FAIL stall_words_sent got=%0d required=%0d", words_sent, ws0 + 1'b1);
    end
    drain();
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    send_code(7'h2A, 1'b0);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    total++;
    if ({out_valid, out_data, out_count, out_last} !== {1'b1, 28'h000002A, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL flush_word got v=%b d=%h c=%0d l=%b required v=1 d=000002a c=1 l=0",
               out_valid, out_data, out_count, out_last);
    end
    drain();
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_empty cyc=%0d got v=%b required=0", i, out_valid);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send_code(7'h61, 1'b0);
    send_code(7'h62, 1'b0);
    pulse_reset();
    total++;
    if ({out_valid, out_data, out_count, out_last, words_sent} !==
        {1'b0, {DW{1'b0}}, 3'd0, 1'b0, {CNTW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_mid_outputs got v=%b d=%h c=%0d l=%b ws=%0d required all 0",
               out_valid, out_data, out_count, out_last, words_sent);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    send_code(7'h71, 1'b0);
    send_code(7'h72, 1'b0);
    send_code(7'h73, 1'b0);
    send_code(7'h74, 1'b0);
    total++;
    if ({out_valid, out_data, out_count} !== {1'b1, 7'h74, 7'h73, 7'h72, 7'h71, 3'd4}) begin
      bad++;
      $display("FAIL reset_mid_clean got v=%b d=%h c=%0d required v=1 d=%h c=4",
               out_valid, out_data, out_count, {7'h74, 7'h73, 7'h72, 7'h71});
    end
    drain();
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = 7'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    drain();
    total++;
    if (words_sent !== sent_cnt) begin
      bad++;
      $display("FAIL random_words_sent got=%0d required=%0d", words_sent, sent_cnt);
    end
  endtask

  task automatic test_wrap;
    pulse_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int i = 0; i < (1 << CNTW) + 1; i++) begin
      for (int k = 0; k < LANES; k++) send_code(7'($urandom), 1'b0);
    end
    drain();
    total++;
    if (words_sent !== CNTW'(1)) begin
      bad++;
      $display("FAIL wrap_words_sent got=%0d required=1", words_sent);
    end
  endtask

  // Sequence
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_code   = 7'h00;
    in_last   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_last();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
